hasti_apb_bridge: RTL and testbench
===================================

// Module: hasti_apb_bridge
// PURPOSE
//  HASTI (AHB-lite) slave bridging the bus I/O region (haddr[31:30]!=0) to a single APB3-style
//  peripheral port. Sits directly downstream of the hasti_bus decoder/mux on its I/O slave port.
//  Converts each accepted AHB transfer into one APB SETUP/ACCESS sequence, inserting wait states.
//  Maps APB errors and unaligned accesses to a two-cycle AHB ERROR response.
//  Bounds stalled peripherals with a timeout.
// PARAMETERS
//  ADDR_W   16   APB address width; paddr = latched haddr[ADDR_W-1:0]
//  TIMEOUT  255  max ACCESS cycles waiting for pready before a forced error; 0 disables the timeout
// PORTS
//  hclk       in   1       bus clock
//  hreset     in   1       reset; synchronous, active-high
//  hsel       in   1       slave select from the decoder
//  haddr      in   32      address phase address
//  hwrite     in   1       1=write
//  hsize      in   3       transfer size; 0=byte, 1=half, 2=word
//  htrans     in   2       IDLE/BUSY/NONSEQ/SEQ (pk_hasti encoding)
//  hready     in   1       bus-wide HREADY
//  hwdata     in   32      write data; held stable by the master while hreadyout=0
//  hreadyout  out  1       slave ready
//  hresp      out  1       OKAY/ERROR
//  hrdata     out  32      read data, registered
//  paddr      out  ADDR_W  APB address
//  psel       out  1       APB select
//  penable    out  1       APB enable
//  pwrite     out  1       APB direction
//  pwdata     out  32      = hwdata while psel=1
//  pstrb      out  4       byte strobes; 0 for reads
//  prdata     in   32      APB read data
//  pready     in   1       APB ready
//  pslverr    in   1       APB error
// BEHAVIOUR
//  - Accept condition: hsel & htrans[1] & hready. Accepting latches haddr, hwrite and hsize.
//  - hsel with htrans IDLE/BUSY, or hready=0: no transfer, OKAY, no state change.
//  - Reset (any state): state=IDLE, psel=0, penable=0, hreadyout=1, hresp=OKAY, hrdata=0,
//    timeout count=0. Reset mid-transfer drops psel on the reset edge; nothing is retried.
//  - FSM states: IDLE, SETUP, ACCESS, DONE, ERR1, ERR2.
//    IDLE  : hreadyout=1, OKAY. Accept with illegal size/alignment -> ERR1.
//            Accept otherwise -> SETUP.
//    SETUP : psel=1, penable=0, hreadyout=0. -> ACCESS unconditionally.
//    ACCESS: psel=1, penable=1, hreadyout=0, timeout count++.
//            pready & !pslverr -> DONE; capture hrdata<=prdata on reads.
//            pready & pslverr, or count reaches TIMEOUT (TIMEOUT!=0) -> ERR1; psel drops.
//    DONE  : hreadyout=1, OKAY. Same accept rules as IDLE (back-to-back); otherwise -> IDLE.
//    ERR1  : hreadyout=0, hresp=ERROR. -> ERR2.
//    ERR2  : hreadyout=1, hresp=ERROR. Same accept rules as IDLE; otherwise -> IDLE.
//  - Zero-wait APB read latency: accept at T, SETUP T+1, ACCESS T+2, DONE T+3
//    (hrdata valid, hreadyout=1).
//  - Illegal transfers: hsize>2; hsize=2 with haddr[1:0]!=0; hsize=1 with haddr[0]=1.
//    An illegal transfer never asserts psel.
//  - pstrb for writes: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
//  - paddr, pwrite and pstrb are held constant from SETUP through the ACCESS exit.
//    Timeout count clears on SETUP entry.
//  - hrdata is held between transfers and is updated only on a successful read completion.
// STRUCTURE
//  - pk_hasti gains: hsize constants (HSIZE_BYTE/HALF/WORD), a function
//    hasti_strb(hsize, addr[1:0]) -> logic [3:0], and a function hasti_aligned(hsize, addr[1:0]).
//  - The state enum is local to this module. No sub-module; one FSM plus the timeout counter.
// TESTING
//  1. Read 0x4000_0010, pready=1, prdata=0xDEADBEEF -> paddr=0x0010, psel for 2 cycles;
//     hrdata=0xDEADBEEF, OKAY at T+3.
//  2. Byte write to 0x4000_0003, hwdata=0xAA000000 -> pstrb=4'b1000, pwdata=0xAA000000, pwrite=1.
//  3. Read with pready low 5 cycles -> ACCESS held 6 cycles, hreadyout=0 throughout, then OKAY.
//  4. Write, pslverr=1 on first pready -> ERR1 (hreadyout=0,ERROR) then ERR2 (hreadyout=1,ERROR).
//  5. Word read at 0x4000_0002 -> no psel; two-cycle ERROR; next NONSEQ in ERR2 accepted normally.
//  6. TIMEOUT=4, pready stuck 0 -> error after 4 ACCESS cycles; hreset asserted in ACCESS
//     -> psel=0 and hreadyout=1 next cycle.

Source files
------------

// File: rtl/hasti_apb_bridge_pkg.sv
// Shared HASTI definitions: transfer encodings plus the size/alignment and
// byte-strobe helpers used by the APB bridge.
package hasti_apb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Sizes above a word are never legal on this 32-bit bus.
  function automatic logic hasti_aligned(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return !addr[0];
      HSIZE_WORD: return addr == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] hasti_strb(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: return 4'b0001 << addr;
      HSIZE_HALF: return 4'b0011 << {addr[1], 1'b0};
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/hasti_apb_bridge.sv
// HASTI slave for the I/O region: each accepted transfer becomes one APB
// SETUP/ACCESS sequence; APB errors, misaligned accesses and timeouts give a two-cycle ERROR.
module hasti_apb_bridge
  import hasti_apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [1:0]        htrans,
  input  logic              hready,
  input  logic [31:0]       hwdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, take, legal, timed_out;
  logic              unused_bits;

  assign unused_bits = ^{haddr[31:ADDR_W], htrans[0]};

  assign accept = hsel & htrans[1] & hready;
  assign legal  = hasti_aligned(hsize, haddr[1:0]);
  // Only the ready states can take a new address phase.
  assign take   = accept & hreadyout;
  // The count holds completed ACCESS cycles, so the last allowed cycle sees TIMEOUT-1.
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  assign hreadyout = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
  assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable   = (state_q == S_ACCESS);
  assign paddr     = addr_q;
  assign pwrite    = write_q;
  assign pwdata    = hwdata;
  assign pstrb     = (psel && write_q) ? hasti_strb(size_q, addr_q[1:0]) : 4'b0000;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) state_d = legal ? S_SETUP : S_ERR1;
        else        state_d = S_IDLE;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready && !pslverr)                state_d = S_DONE;
        else if ((pready && pslverr) || timed_out) state_d = S_ERR1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      cnt_q   <= '0;
      hrdata  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q  <= haddr[ADDR_W-1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
      if (state_d == S_SETUP)       cnt_q <= '0;
      else if (state_q == S_ACCESS) cnt_q <= cnt_q + 1'b1;
      if (state_q == S_ACCESS && pready && !pslverr && !write_q) hrdata <= prdata;
    end
  end

endmodule

// File: tb/tb_hasti_apb_bridge.sv
// Bench for hasti_apb_bridge: directed AHB transfers against a scripted APB
// responder, with expected AHB and APB responses checked by a monitor.
module tb_hasti_apb_bridge;
  import hasti_apb_bridge_pkg::*;

  typedef struct packed {
    logic [7:0]  lat;
    logic        resp;
    logic [31:0] rdata;
  } ahb_exp_t;

  typedef struct packed {
    logic [7:0]  cyc;
    logic [15:0] paddr;
    logic        pwrite;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } apb_exp_t;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel = 1'b0;
  logic        hsel_to = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [31:0] hwdata = 32'h0;
  logic        hready_block = 1'b0;
  logic        hready, hready_to;
  logic        hreadyout, hresp, psel, penable, pwrite;
  logic [31:0] hrdata, pwdata;
  logic [15:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        hreadyout_to, hresp_to, psel_to, penable_to, pwrite_to;
  logic [31:0] hrdata_to, pwdata_to;
  logic [15:0] paddr_to;
  logic [3:0]  pstrb_to;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cfg_wait = 0;
  logic        cfg_err = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  ahb_exp_t    ahb_exp_q[$];
  apb_exp_t    apb_exp_q[$];

  always #5 hclk = ~hclk;

  assign hready    = hreadyout & ~hready_block;
  assign hready_to = hreadyout_to;

  hasti_apb_bridge dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hready(hready), .hwdata(hwdata),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  hasti_apb_bridge #(.TIMEOUT(4)) dut_to (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_to), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hready(hready_to), .hwdata(hwdata),
    .hreadyout(hreadyout_to), .hresp(hresp_to), .hrdata(hrdata_to), .paddr(paddr_to),
    .psel(psel_to), .penable(penable_to), .pwrite(pwrite_to), .pwdata(pwdata_to),
    .pstrb(pstrb_to), .prdata(32'h0), .pready(1'b0), .pslverr(1'b0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // APB responder: pready rises after cfg_wait stalled ACCESS cycles.
  int acc_cnt = 0;
  always begin
    @(posedge hclk);
    #1;
    if (psel && penable) begin
      pready  = (acc_cnt == cfg_wait);
      pslverr = pready & cfg_err;
      prdata  = cfg_rdata;
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      acc_cnt = 0;
    end
  end

  // Monitor: pops expectations on APB completion and on the AHB response cycle.
  int       psel_cnt = 0;
  int       lat = 0;
  logic     busy = 1'b0;
  logic     err1_seen = 1'b0;
  always @(negedge hclk) begin
    ahb_exp_t a;
    apb_exp_t p;
    if (hreset) begin
      busy = 1'b0;
      psel_cnt = 0;
    end else begin
      if (psel) begin
        psel_cnt++;
        if (!penable && psel_cnt == 1) check("apb_expected", 32'(apb_exp_q.size() != 0), 32'd1);
        if (penable && pready) begin
          if (apb_exp_q.size() != 0) begin
            p = apb_exp_q.pop_front();
            check("apb_cycles", 32'(psel_cnt), 32'(p.cyc));
            check("apb_paddr", 32'(paddr), 32'(p.paddr));
            check("apb_pwrite", 32'(pwrite), 32'(p.pwrite));
            check("apb_pstrb", 32'(pstrb), 32'(p.strb));
            if (p.pwrite) check("apb_pwdata", pwdata, p.wdata);
          end
          psel_cnt = 0;
        end
      end else begin
        psel_cnt = 0;
      end
      if (busy) begin
        lat++;
        if (hreadyout) begin
          busy = 1'b0;
          if (ahb_exp_q.size() == 0) begin
            check("ahb_expected", 32'd0, 32'd1);
          end else begin
            a = ahb_exp_q.pop_front();
            check("ahb_latency", 32'(lat), 32'(a.lat));
            check("ahb_hresp", 32'(hresp), 32'(a.resp));
            check("ahb_hrdata", hrdata, a.rdata);
            if (a.resp) check("ahb_err1_cycle", 32'(err1_seen), 32'd1);
          end
        end
        err1_seen = !hreadyout && hresp;
      end
      if (hsel && htrans[1] && hready) begin
        busy = 1'b1;
        lat = 0;
        err1_seen = 1'b0;
      end
    end
  end

  // Issues one address phase from a ready cycle and returns on the response cycle.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, input int wt, input logic err,
                      input logic [31:0] prd, input logic legal, input logic [3:0] strb,
                      input logic [31:0] exp_rdata);
    ahb_exp_t a;
    apb_exp_t p;
    int n;
    a.resp  = !legal || err;
    a.lat   = legal ? (err ? 8'(4 + wt) : 8'(3 + wt)) : 8'd2;
    a.rdata = exp_rdata;
    ahb_exp_q.push_back(a);
    if (legal) begin
      p.cyc    = 8'(2 + wt);
      p.paddr  = addr[15:0];
      p.pwrite = wr;
      p.strb   = wr ? strb : 4'b0000;
      p.wdata  = wdata;
      apb_exp_q.push_back(p);
    end
    cfg_wait  = wt;
    cfg_err   = err;
    cfg_rdata = prd;
    hsel   = 1'b1;
    htrans = HTRANS_NONSEQ;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    @(posedge hclk); #2;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = wdata;
    n = 0;
    while (!hreadyout && n < 100) begin
      @(posedge hclk); #2;
      n++;
    end
    if (!hreadyout) check("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge hclk); #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1;
    idle(2);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    hreset = 1'b0;
    idle(2);

    xfer(32'h4000_0010, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b1, 4'b0000, 32'hDEAD_BEEF);
    idle(1);
    xfer(32'h4000_0003, 1'b1, HSIZE_BYTE, 32'hAA00_0000, 0, 1'b0, 32'h0, 1'b1, 4'b1000, 32'hDEAD_BEEF);
    xfer(32'h4000_FFFC, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b1, 4'b0000, 32'hCAFE_F00D);
    xfer(32'h4000_0124, 1'b0, HSIZE_WORD, 32'h0, 5, 1'b0, 32'h1234_5678, 1'b1, 4'b0000, 32'h1234_5678);
    idle(1);
    xfer(32'h4000_0008, 1'b1, HSIZE_WORD, 32'h1122_3344, 0, 1'b1, 32'h0, 1'b1, 4'b1111, 32'h1234_5678);
    idle(1);
    xfer(32'h4000_0002, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h1234_5678);
    xfer(32'h4000_0006, 1'b1, HSIZE_HALF, 32'h5A5A_0000, 0, 1'b0, 32'h0, 1'b1, 4'b1100, 32'h1234_5678);
    xfer(32'h4000_0001, 1'b0, HSIZE_HALF, 32'h0, 0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h1234_5678);
    xfer(32'h4000_0000, 1'b0, 3'd3, 32'h0, 0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h1234_5678);
    idle(1);
    // Failed read must leave hrdata untouched.
    xfer(32'h4000_0040, 1'b0, HSIZE_WORD, 32'h0, 2, 1'b1, 32'hFFFF_FFFF, 1'b1, 4'b0000, 32'h1234_5678);
    idle(1);

    hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h4000_0010;
    idle(1);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    check("busy_no_psel", 32'(psel), 32'd0);
    check("busy_hreadyout", 32'(hreadyout), 32'd1);
    idle(1);
    check("busy_no_psel_2", 32'(psel), 32'd0);

    hready_block = 1'b1; hsel = 1'b1; htrans = HTRANS_NONSEQ;
    idle(1);
    hsel = 1'b0; htrans = HTRANS_IDLE; hready_block = 1'b0;
    check("hready0_no_psel", 32'(psel), 32'd0);
    check("hready0_hreadyout", 32'(hreadyout), 32'd1);
    idle(1);
    check("hready0_no_psel_2", 32'(psel), 32'd0);

    xfer(32'h4000_0022, 1'b0, HSIZE_HALF, 32'h0, 1, 1'b0, 32'h0000_BEEF, 1'b1, 4'b0000, 32'h0000_BEEF);
    idle(2);

    // Timeout instance: pready never rises.
    hsel_to = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h4000_0020; hwrite = 1'b0; hsize = HSIZE_WORD;
    idle(1);
    hsel_to = 1'b0; htrans = HTRANS_IDLE;
    check("to_setup_psel", 32'(psel_to), 32'd1);
    check("to_setup_penable", 32'(penable_to), 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check("to_access_penable", 32'(penable_to), 32'd1);
      check("to_access_hreadyout", 32'(hreadyout_to), 32'd0);
    end
    idle(1);
    check("to_err1_psel", 32'(psel_to), 32'd0);
    check("to_err1_hreadyout", 32'(hreadyout_to), 32'd0);
    check("to_err1_hresp", 32'(hresp_to), 32'd1);
    idle(1);
    check("to_err2_hreadyout", 32'(hreadyout_to), 32'd1);
    check("to_err2_hresp", 32'(hresp_to), 32'd1);
    idle(1);
    check("to_idle_hresp", 32'(hresp_to), 32'd0);

    hsel_to = 1'b1; htrans = HTRANS_NONSEQ;
    idle(1);
    hsel_to = 1'b0; htrans = HTRANS_IDLE;
    idle(1);
    check("rst_mid_access", 32'(penable_to), 32'd1);
    hreset = 1'b1;
    idle(1);
    check("rst_mid_psel", 32'(psel_to), 32'd0);
    check("rst_mid_penable", 32'(penable_to), 32'd0);
    check("rst_mid_hreadyout", 32'(hreadyout_to), 32'd1);
    check("rst_mid_hresp", 32'(hresp_to), 32'd0);
    hreset = 1'b0;
    idle(2);

    check("ahb_queue_empty", 32'(ahb_exp_q.size()), 32'd0);
    check("apb_queue_empty", 32'(apb_exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
